// File: rtl/nf10_axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter that merges C_NUM_PORTS AXI4-Stream inputs
// onto one stream through a single registered output stage.
module nf10_axis_pkt_arbiter #(
  parameter int unsigned C_NUM_PORTS        = 4,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_PKT_CNT_WIDTH    = 32
) (
  input  logic                                          ACLK,
  input  logic                                          ARESET,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic [C_NUM_PORTS-1:0]                        S_AXIS_TLAST,
  input  logic [C_NUM_PORTS-1:0]                        S_AXIS_TVALID,
  output logic [C_NUM_PORTS-1:0]                        S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                 M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]               M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 M_AXIS_TUSER,
  output logic                                          M_AXIS_TLAST,
  output logic                                          M_AXIS_TVALID,
  input  logic                                          M_AXIS_TREADY,
  output logic [2:0]                                    CUR_GRANT,
  output logic                                          BUSY,
  output logic [C_PKT_CNT_WIDTH-1:0]                    PKT_CNT
);

  localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [2:0]      last_grant;
  logic [2:0]      sel;
  logic [DW-1:0]   g_data;
  logic [SW-1:0]   g_strb;
  logic [UW-1:0]   g_user;
  logic            g_last, g_valid;
  logic            rdy, in_hs, out_hs;

  always_comb begin
    g_data  = '0;
    g_strb  = '0;
    g_user  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      if (CUR_GRANT == 3'(i)) begin
        g_data  = S_AXIS_TDATA[i*DW +: DW];
        g_strb  = S_AXIS_TSTRB[i*SW +: SW];
        g_user  = S_AXIS_TUSER[i*UW +: UW];
        g_last  = S_AXIS_TLAST[i];
        g_valid = S_AXIS_TVALID[i];
      end
    end
  end

  assign rdy    = (state == LOCKED) && (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign in_hs  = rdy && g_valid;
  assign out_hs = M_AXIS_TVALID && M_AXIS_TREADY;
  assign BUSY   = (state == LOCKED);

  always_comb begin
    for (int unsigned i = 0; i < C_NUM_PORTS; i++)
      S_AXIS_TREADY[i] = rdy && (CUR_GRANT == 3'(i));
  end

  // Pick the requester with the smallest rotational distance past last_grant.
  always_comb begin
    int unsigned d, best;
    d    = 0;
    best = C_NUM_PORTS;
    sel  = '0;
    for (int unsigned j = 0; j < C_NUM_PORTS; j++) begin
      d = (j + C_NUM_PORTS - 32'(last_grant) - 1) % C_NUM_PORTS;
      if (S_AXIS_TVALID[j] && d < best) begin
        best = d;
        sel  = 3'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|S_AXIS_TVALID)   state_nxt = LOCKED;
      LOCKED:  if (in_hs && g_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      CUR_GRANT  <= '0;
      last_grant <= 3'(C_NUM_PORTS - 1);
      PKT_CNT    <= '0;
    end else if (state == IDLE) begin
      if (|S_AXIS_TVALID) CUR_GRANT <= sel;
    end else if (in_hs && g_last) begin
      last_grant <= CUR_GRANT;
      PKT_CNT    <= PKT_CNT + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TUSER  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (in_hs) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= g_data;
      M_AXIS_TSTRB  <= g_strb;
      M_AXIS_TUSER  <= g_user;
      M_AXIS_TLAST  <= g_last;
    end else if (out_hs) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

endmodule
